// File: rtl/regs_pkg.sv
// Shared constants, types and write-port arbitration helper for the multi-port register file.
package regs_pkg;

  localparam int unsigned XlenDefault  = 32;
  localparam int unsigned NregsDefault = 32;
  localparam int unsigned AwDefault    = $clog2(NregsDefault);

  // Widest write-port configuration supported by the arbitration helper.
  localparam int unsigned MaxWr  = 2;
  localparam int unsigned WrIdxW = $clog2(MaxWr);

  typedef logic [AwDefault-1:0]   reg_adr_t;
  typedef logic [XlenDefault-1:0] reg_word_t;
  typedef logic [WrIdxW-1:0]      wr_idx_t;

  // Given the per-port address-match vector for one register, return the index of the
  // port whose data lands there; the highest-index matching port wins.
  function automatic wr_idx_t win_port(input logic [MaxWr-1:0] hit);
    wr_idx_t idx;
    idx = '0;
    for (int k = 0; k < int'(MaxWr); k++) begin
      if (hit[k]) begin
        idx = wr_idx_t'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/regs_bypass.sv
// One read port: selects the stored word, a forwarded same-cycle write, or the hardwired zero.
module regs_bypass
  import regs_pkg::*;
#(
  parameter int unsigned XLEN    = XlenDefault,
  parameter int unsigned AW      = AwDefault,
  parameter int unsigned NWR     = 2,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_X0 = 1'b1
) (
  input  logic              byp_en_i,
  input  logic [AW-1:0]     radr_i,
  input  logic [XLEN-1:0]   word_i,
  input  logic [NWR-1:0]    wen_i,
  input  logic [NWR*AW-1:0] wadr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              hit_o
);

  logic [MaxWr-1:0] match;
  wr_idx_t          sel;

  always_comb begin
    match = '0;
    for (int k = 0; k < int'(NWR); k++) begin
      match[k] = wen_i[k] && (wadr_i[k*AW +: AW] == radr_i);
    end
    sel     = win_port(match);
    hit_o   = BYPASS && byp_en_i && (|match);
    rdata_o = word_i;
    if (hit_o) begin
      rdata_o = wdata_i[int'(sel)*XLEN +: XLEN];
    end
    // x0 overrides everything, including a forwarded write to it.
    if (ZERO_X0 && (radr_i == '0)) begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/regs_mp.sv
// Multi-port register file with per-register pending scoreboard for RAW hazard detection.
module regs_mp
  import regs_pkg::*;
#(
  parameter int unsigned XLEN    = XlenDefault,
  parameter int unsigned NREGS   = NregsDefault,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 2,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_X0 = 1'b1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   wadr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   radr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_adr,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NRD-1:0]   byp_hit;
  logic [AW-1:0]    ra;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int k = 0; k < int'(NWR); k++) begin
      if (wen[k]) begin
        mem_d[wadr[k*AW +: AW]]  = wdata[k*XLEN +: XLEN];
        busy_d[wadr[k*AW +: AW]] = 1'b0;
      end
    end
    // Issue after writeback clear: a newer producer keeps the register pending.
    if (iss_valid) begin
      busy_d[iss_adr] = 1'b1;
    end
    if (ZERO_X0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    regs_bypass #(
      .XLEN    (XLEN),
      .AW      (AW),
      .NWR     (NWR),
      .BYPASS  (BYPASS),
      .ZERO_X0 (ZERO_X0)
    ) u_bypass (
      .byp_en_i (reset),
      .radr_i   (radr[i*AW +: AW]),
      .word_i   (mem_q[radr[i*AW +: AW]]),
      .wen_i    (wen),
      .wadr_i   (wadr),
      .wdata_i  (wdata),
      .rdata_o  (rdata[i*XLEN +: XLEN]),
      .hit_o    (byp_hit[i])
    );
  end

  always_comb begin
    ra    = '0;
    rbusy = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      ra       = radr[i*AW +: AW];
      rbusy[i] = busy_q[ra] && !byp_hit[i];
      if (ZERO_X0 && (ra == '0)) begin
        rbusy[i] = 1'b0;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regs_mp.sv
// Scoreboard bench for regs_mp: three configurations share one stimulus stream.
module tb_regs_mp;

  // Instance 0: 32x32 bypass, x0 zero. 1: same without bypass. 2: 64-bit, 16 regs, 3 reads, real x0.
  logic clk = 1'b0;
  logic reset, iss_valid;
  logic [1:0] wen;

  logic [9:0]   wadr_a, wadr_b, radr_a, radr_b;
  logic [63:0]  wdata_a, wdata_b, rdata_a, rdata_b;
  logic [1:0]   rbusy_a, rbusy_b;
  logic [4:0]   iss_adr_a, iss_adr_b;
  logic [31:0]  busy_a, busy_b;
  logic [7:0]   wadr_c;
  logic [11:0]  radr_c;
  logic [127:0] wdata_c;
  logic [191:0] rdata_c;
  logic [2:0]   rbusy_c;
  logic [3:0]   iss_adr_c;
  logic [15:0]  busy_c;

  always #5 clk = ~clk;

  regs_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1), .ZERO_X0(1'b1)) u_a (
    .clk(clk), .reset(reset), .wen(wen), .wadr(wadr_a), .wdata(wdata_a), .radr(radr_a),
    .rdata(rdata_a), .rbusy(rbusy_a), .iss_valid(iss_valid), .iss_adr(iss_adr_a), .busy(busy_a)
  );
  regs_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b0), .ZERO_X0(1'b1)) u_b (
    .clk(clk), .reset(reset), .wen(wen), .wadr(wadr_b), .wdata(wdata_b), .radr(radr_b),
    .rdata(rdata_b), .rbusy(rbusy_b), .iss_valid(iss_valid), .iss_adr(iss_adr_b), .busy(busy_b)
  );
  regs_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(2), .BYPASS(1'b1), .ZERO_X0(1'b0)) u_c (
    .clk(clk), .reset(reset), .wen(wen), .wadr(wadr_c), .wdata(wdata_c), .radr(radr_c),
    .rdata(rdata_c), .rbusy(rbusy_c), .iss_valid(iss_valid), .iss_adr(iss_adr_c), .busy(busy_c)
  );

  typedef struct packed {
    logic             rst;
    logic [1:0]       wen;
    logic [1:0][4:0]  wadr;
    logic [1:0][63:0] wdata;
    logic [2:0][4:0]  radr;
    logic             iss_v;
    logic [4:0]       iss_adr;
  } stim_t;

  typedef struct packed {
    logic [2:0][2:0][63:0] rd;
    logic [2:0][2:0]       rb;
    logic [2:0][31:0]      bz;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t  expq[$];
  stim_t cur, s;

  // Reference state: plain arrays per instance.
  logic [63:0] mem_m [3][32];
  logic [31:0] bm [3];

  function automatic int nrd(int d);  return (d == 2) ? 3 : 2; endfunction
  function automatic bit byp(int d);  return d != 1;           endfunction
  function automatic bit zx(int d);   return d != 2;           endfunction
  function automatic logic [4:0] madr(int d, logic [4:0] a);
    return (d == 2) ? {1'b0, a[3:0]} : a;
  endfunction
  function automatic logic [63:0] mdat(int d, logic [63:0] v);
    return (d == 2) ? v : {32'b0, v[31:0]};
  endfunction

  function automatic stim_t idle();
    stim_t t;
    t = '0;
    t.rst = 1'b1;
    return t;
  endfunction

  function automatic exp_t model_expect(stim_t t);
    exp_t e;
    logic hit;
    logic [63:0] val;
    logic [4:0] a;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      e.bz[d] = bm[d];
      for (int i = 0; i < nrd(d); i++) begin
        a = madr(d, t.radr[i]);
        hit = 1'b0;
        val = '0;
        for (int k = 0; k < 2; k++) begin
          if (t.wen[k] && madr(d, t.wadr[k]) == a) begin
            hit = 1'b1;
            val = mdat(d, t.wdata[k]);
          end
        end
        if (zx(d) && a == 5'd0) begin
          e.rd[d][i] = '0;
        end else if (byp(d) && t.rst && hit) begin
          e.rd[d][i] = val;
        end else begin
          e.rd[d][i] = mem_m[d][a];
          e.rb[d][i] = bm[d][a];
        end
      end
    end
    return e;
  endfunction

  function automatic void model_edge(stim_t t);
    logic [4:0] a;
    for (int d = 0; d < 3; d++) begin
      if (!t.rst) begin
        for (int r = 0; r < 32; r++) mem_m[d][r] = '0;
        bm[d] = '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          a = madr(d, t.wadr[k]);
          if (t.wen[k]) begin
            if (!(zx(d) && a == 5'd0)) mem_m[d][a] = mdat(d, t.wdata[k]);
            bm[d][a] = 1'b0;
          end
        end
        a = madr(d, t.iss_adr);
        if (t.iss_v && !(zx(d) && a == 5'd0)) bm[d][a] = 1'b1;
      end
    end
  endfunction

  task automatic apply(input stim_t t);
    reset     = t.rst;
    wen       = t.wen;
    iss_valid = t.iss_v;
    for (int k = 0; k < 2; k++) begin
      wadr_a[k*5 +: 5]   = t.wadr[k];
      wadr_b[k*5 +: 5]   = t.wadr[k];
      wadr_c[k*4 +: 4]   = t.wadr[k][3:0];
      wdata_a[k*32 +: 32] = t.wdata[k][31:0];
      wdata_b[k*32 +: 32] = t.wdata[k][31:0];
      wdata_c[k*64 +: 64] = t.wdata[k];
    end
    for (int i = 0; i < 2; i++) begin
      radr_a[i*5 +: 5] = t.radr[i];
      radr_b[i*5 +: 5] = t.radr[i];
    end
    for (int i = 0; i < 3; i++) radr_c[i*4 +: 4] = t.radr[i][3:0];
    iss_adr_a = t.iss_adr;
    iss_adr_b = t.iss_adr;
    iss_adr_c = t.iss_adr[3:0];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: commit the previous stimulus into the model, then present the next one.
  task automatic cycle(input stim_t t);
    @(posedge clk);
    model_edge(cur);
    #1;
    cur = t;
    apply(t);
    expq.push_back(model_expect(t));
    #1;
  endtask

  function automatic logic [63:0] act_rd(int d, int i);
    case (d)
      0:       return {32'b0, rdata_a[i*32 +: 32]};
      1:       return {32'b0, rdata_b[i*32 +: 32]};
      default: return rdata_c[i*64 +: 64];
    endcase
  endfunction

  function automatic logic act_rb(int d, int i);
    case (d)
      0:       return rbusy_a[i];
      1:       return rbusy_b[i];
      default: return rbusy_c[i];
    endcase
  endfunction

  function automatic logic [31:0] act_bz(int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return {16'b0, busy_c};
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int d = 0; d < 3; d++) begin
          for (int i = 0; i < nrd(d); i++) begin
            check($sformatf("d%0d_rdata%0d", d, i), act_rd(d, i), e.rd[d][i]);
            check($sformatf("d%0d_rbusy%0d", d, i), 64'(act_rb(d, i)), 64'(e.rb[d][i]));
          end
          check($sformatf("d%0d_busy", d), 64'(act_bz(d)), 64'(e.bz[d]));
        end
      end
    end
  end

  initial begin : driver
    cur = idle();
    cur.rst = 1'b0;
    apply(cur);

    // Reset clears preloaded data and drops a same-cycle write.
    s = idle(); s.wen = 2'b01; s.wadr[0] = 5'd1; s.wdata[0] = 64'hABCD1234; cycle(s);
    s = idle(); s.radr[0] = 5'd1; cycle(s);
    check("preload_x1", {32'b0, rdata_a[31:0]}, 64'hABCD1234);
    s = idle(); s.rst = 1'b0; s.wen = 2'b01; s.wadr[0] = 5'd2; s.wdata[0] = 64'h5555;
    s.radr[0] = 5'd1; s.radr[1] = 5'd2; s.iss_v = 1'b1; s.iss_adr = 5'd4; cycle(s);
    s = idle(); s.radr[0] = 5'd1; s.radr[1] = 5'd2; cycle(s);
    check("reset_x1", {32'b0, rdata_a[31:0]}, 64'h0);
    check("reset_x2", {32'b0, rdata_a[63:32]}, 64'h0);
    check("reset_busy", {32'b0, busy_a}, 64'h0);

    // Dual write to one address: port 1 wins.
    s = idle(); s.wen = 2'b11; s.wadr[0] = 5'd5; s.wadr[1] = 5'd5;
    s.wdata[0] = 64'h11111111; s.wdata[1] = 64'h22222222; cycle(s);
    s = idle(); s.radr[0] = 5'd5; s.radr[1] = 5'd5; cycle(s);
    check("dual_p0", {32'b0, rdata_a[31:0]}, 64'h22222222);
    check("dual_p1", {32'b0, rdata_a[63:32]}, 64'h22222222);

    // Bypass versus registered visibility.
    s = idle(); s.wen = 2'b01; s.wadr[0] = 5'd3; s.wdata[0] = 64'hDEADBEEF; s.radr[0] = 5'd3;
    cycle(s);
    check("bypass_same", {32'b0, rdata_a[31:0]}, 64'hDEADBEEF);
    check("nobypass_same", {32'b0, rdata_b[31:0]}, 64'h0);
    s = idle(); s.radr[0] = 5'd3; cycle(s);
    check("nobypass_next", {32'b0, rdata_b[31:0]}, 64'hDEADBEEF);

    // x0 stays zero and never busy.
    s = idle(); s.wen = 2'b01; s.wadr[0] = 5'd0; s.wdata[0] = 64'hFFFFFFFF; cycle(s);
    check("x0_same", {32'b0, rdata_a[31:0]}, 64'h0);
    s = idle(); cycle(s);
    check("x0_next", {32'b0, rdata_a[31:0]}, 64'h0);
    s = idle(); s.iss_v = 1'b1; s.iss_adr = 5'd0; cycle(s);
    s = idle(); cycle(s);
    check("x0_busy", 64'(busy_a[0]), 64'h0);

    // Scoreboard set, forwarded clear, set-wins-over-clear.
    s = idle(); s.iss_v = 1'b1; s.iss_adr = 5'd7; cycle(s);
    s = idle(); s.radr[0] = 5'd7; cycle(s);
    check("busy7_set", 64'(busy_a[7]), 64'h1);
    check("rbusy7_set", 64'(rbusy_a[0]), 64'h1);
    s = idle(); s.wen = 2'b01; s.wadr[0] = 5'd7; s.wdata[0] = 64'h7; s.radr[0] = 5'd7; cycle(s);
    check("rbusy7_fwd", 64'(rbusy_a[0]), 64'h0);
    check("rbusy7_nofwd", 64'(rbusy_b[0]), 64'h1);
    s = idle(); s.radr[0] = 5'd7; cycle(s);
    check("busy7_clr", 64'(busy_a[7]), 64'h0);
    s = idle(); s.iss_v = 1'b1; s.iss_adr = 5'd9; s.wen = 2'b10; s.wadr[1] = 5'd9;
    s.wdata[1] = 64'h99; cycle(s);
    s = idle(); s.radr[0] = 5'd9; cycle(s);
    check("busy9_setwins", 64'(busy_a[9]), 64'h1);
    check("x9_data", {32'b0, rdata_a[31:0]}, 64'h99);

    // Sweep: xi=i via alternating ports, then read every register on every port.
    for (int i = 0; i < 32; i++) begin
      s = idle();
      s.wen = (i % 2 == 0) ? 2'b01 : 2'b10;
      s.wadr[i % 2] = 5'(i);
      s.wdata[i % 2] = 64'(i);
      cycle(s);
    end
    for (int i = 0; i < 32; i++) begin
      s = idle();
      for (int j = 0; j < 3; j++) s.radr[j] = 5'(i);
      cycle(s);
      if (i == 31) check("sweep_x31", {32'b0, rdata_a[63:32]}, 64'd31);
    end

    // Random traffic, biased toward a few addresses so hits and collisions occur.
    for (int n = 0; n < 400; n++) begin
      s.rst = ($urandom_range(0, 31) != 0);
      s.wen = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        s.wadr[k]  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        s.wdata[k] = {$urandom, $urandom};
      end
      for (int j = 0; j < 3; j++) begin
        s.radr[j] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      end
      s.iss_v   = 1'($urandom);
      s.iss_adr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      cycle(s);
    end

    s = idle();
    cycle(s);
    @(negedge clk);
    #1;
    check("queue_drained", 64'(expq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
Parametrised multi-port register file. It is the successor to the single-write, dual-read `regs` block used by the core.
- Configurable data width, register count, read-port count and write-port count.
- Optional same-cycle write-to-read bypass.
- Optional hardwired-zero x0.
- Per-register pending (busy) scoreboard, so a pipelined or dual-issue core can detect RAW hazards against in-flight producers.
- Sits between decode/issue (read, issue marking) and writeback (write, busy clear).

Parameters:
- XLEN, 32, data width per register.
- NREGS, 32, number of registers, power of two >= 2; AW = $clog2(NREGS).
- NRD, 2, number of read ports, 1..4.
- NWR, 2, number of write ports, 1..2.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads.
- ZERO_X0, 1, 1 = register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset is synchronous and active-low (0 = reset), sampled on the rising edge of clk.
- wen  in  NWR  per-port write enable.
- wadr  in  NWR*AW  write addresses; port k at [k*AW +: AW].
- wdata  in  NWR*XLEN  write data; port k at [k*XLEN +: XLEN].
- radr  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rdata  out  NRD*XLEN  read data, combinational.
- rbusy  out  NRD  busy status of each read address, combinational.
- iss_valid  in  1  issue strobe: mark iss_adr pending.
- iss_adr  in  AW  destination register of the issued instruction.
- busy  out  NREGS  registered scoreboard vector.

Behaviour:
- Storage: NREGS x XLEN array plus NREGS busy flops.
- Reset, on a clk edge with reset=0:
  - all registers become 0 and busy becomes 0;
  - reset has priority over wen and iss_valid in that cycle;
  - after the edge: rdata = 0 for every address, rbusy = 0.
- While reset=0, bypass is suppressed and rdata shows the stored array contents. Reset may assert mid-operation; all in-flight writes and issues in that cycle are discarded.
- Write:
  - wen[k]=1 stores wdata[k] into wadr[k] at the edge.
  - If two ports target the same address in the same cycle, the higher-index port wins.
  - With ZERO_X0=1, writes to address 0 are dropped.
- Read, zero latency (combinational):
  - Default: rdata[i] = array[radr[i]].
  - With BYPASS=1 and reset=1: if any wen[k] has wadr[k]==radr[i], rdata[i] = wdata of the highest such k.
  - With ZERO_X0=1, radr[i]==0 always yields 0, overriding bypass.
  - With BYPASS=0, the new value is visible from the cycle after the write edge.
- Scoreboard:
  - iss_valid=1 sets busy[iss_adr] at the edge.
  - A write to address a clears busy[a] at the edge.
  - Simultaneous set and clear of the same address: set wins (a newer producer is in flight).
  - A write to a non-busy register is legal: data is stored, busy stays 0.
  - With ZERO_X0=1, busy[0] is constant 0 and issue to 0 is ignored.
- rbusy[i] = busy[radr[i]], except:
  - with BYPASS=1 and a same-cycle write to radr[i], rbusy[i]=0 (the value is being forwarded);
  - with ZERO_X0=1 and radr[i]==0, rbusy[i]=0.
- Widths: addresses are never out of range (NREGS is a power of two); no sign or zero extension of data.

Decomposition:
- Package regs_pkg holds:
  - the default XLEN/NREGS constants;
  - typedefs for reg address and data word;
  - a function returning the winning write-port index for a given address.
- One sub-module, regs_bypass: one instance per read port. It takes radr, the array word and all write ports, and produces rdata and the bypass-hit flag.
- The storage and scoreboard stay in the top module.

Test Plan:
1. Reset:
   - Preload x1=32'hABCD1234, then pulse reset=0 for one edge.
   - Required: x1 reads 0 and busy=0.
   - With reset=0 and wen[0]=1 to x2 in the same cycle, x2 reads 0 after the edge.
2. Dual write, same address:
   - wen=2'b11, wadr0=wadr1=5, wdata0=32'h11111111, wdata1=32'h22222222.
   - Required: next cycle x5 reads 32'h22222222 on both read ports.
3. Bypass:
   - BYPASS=1: wen[0]=1, wadr0=3, wdata0=32'hDEADBEEF, radr0=3.
   - Required: rdata0=32'hDEADBEEF in the same cycle.
   - Rerun with BYPASS=0: same cycle shows the old value 0, next cycle shows 32'hDEADBEEF.
4. x0:
   - ZERO_X0=1: write 32'hFFFFFFFF to 0 while radr0=0.
   - Required: rdata0=0 in the same and next cycle.
   - Then iss_valid=1, iss_adr=0: busy[0] stays 0.
5. Scoreboard:
   - iss_valid=1, iss_adr=7 -> next cycle busy[7]=1 and rbusy=1 for radr=7.
   - Write x7=32'h00000007 -> same cycle rbusy=0 (BYPASS=1); next cycle busy[7]=0.
   - Issue and write of x9 in the same cycle -> busy[9]=1 and x9 updated.
6. Sweep:
   - Write xi=i for i=0..NREGS-1 through alternating write ports, then read all over every read port.
   - Required: value i for i>0 and 0 for x0.
   - Repeat for XLEN=64, NREGS=16, NRD=3.
